// File: rtl/encoder4to2_serial.sv
// encoder4to2_serial: emits the 2-bit index of each set bit of a request word, one per handshake beat
module encoder4to2_serial #(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] i,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] o,
  output logic       out_last,
  output logic       zero_err
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic       zero_err_q, zero_err_d;
  logic [1:0] idx;
  logic       beat, accept;
  // Priority pick, handshakes and next-state; a final beat may accept the next word with no bubble
  always_comb begin
    idx = PRIORITY_HIGH ? (pending_q[3] ? 2'd3 : pending_q[2] ? 2'd2 : pending_q[1] ? 2'd1 : 2'd0)
                        : (pending_q[0] ? 2'd0 : pending_q[1] ? 2'd1 : pending_q[2] ? 2'd2 : 2'd3);
    out_valid = state_q == BUSY;
    o = out_valid ? idx : 2'd0;
    out_last = out_valid && ($countones(pending_q) == 1);
    beat = out_valid && out_ready;
    in_ready = !out_valid || (beat && out_last);
    accept = in_valid && in_ready;
    pending_d = accept ? i : beat ? (pending_q & ~(4'b0001 << idx)) : pending_q;
    state_d = (pending_d != 4'd0) ? BUSY : IDLE;
    zero_err_d = accept && (i == 4'd0);
  end
  // State, pending bits and the registered zero-word pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= 4'd0;
      zero_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end
  assign zero_err = zero_err_q;
endmodule

// File: tb/tb_encoder4to2_serial.sv
// tb_encoder4to2_serial: directed vector table plus randomized run against a queue-based model
module tb_encoder4to2_serial;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] i = 4'd0;
  logic in_ready_l, out_valid_l, out_last_l, zero_err_l;
  logic in_ready_h, out_valid_h, out_last_h, zero_err_h;
  logic [1:0] o_l, o_h;
  int checks = 0, errors = 0;
  int q_lo[$], q_hi[$];
  bit zerr_m = 1'b0;

  always #5 clk = ~clk;

  encoder4to2_serial #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .i(i),
    .out_valid(out_valid_l), .out_ready(out_ready), .o(o_l), .out_last(out_last_l), .zero_err(zero_err_l));
  encoder4to2_serial #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h), .i(i),
    .out_valid(out_valid_h), .out_ready(out_ready), .o(o_h), .out_last(out_last_h), .zero_err(zero_err_h));

  typedef struct {
    int chk, rst, iv, i, ordy;
    int ov, olo, ohi, last, irdy, zerr;
  } vec_t;
  vec_t tbl[25];

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input int ov, input int olo, input int ohi, input int last, input int irdy, input int zerr);
    cmp("out_valid_lo", int'(out_valid_l), ov);
    cmp("out_valid_hi", int'(out_valid_h), ov);
    cmp("o_lo", int'(o_l), olo);
    cmp("o_hi", int'(o_h), ohi);
    cmp("out_last_lo", int'(out_last_l), last);
    cmp("out_last_hi", int'(out_last_h), last);
    cmp("in_ready_lo", int'(in_ready_l), irdy);
    cmp("in_ready_hi", int'(in_ready_h), irdy);
    cmp("zero_err_lo", int'(zero_err_l), zerr);
    cmp("zero_err_hi", int'(zero_err_h), zerr);
  endtask

  // Advance the reference by one clock using the values currently driven
  task automatic model_step();
    bit beat, rdy, acc;
    if (rst) begin
      q_lo.delete();
      q_hi.delete();
      zerr_m = 1'b0;
      return;
    end
    beat = (q_lo.size() > 0) && out_ready;
    rdy = (q_lo.size() == 0) || (beat && q_lo.size() == 1);
    acc = in_valid && rdy;
    if (beat) begin
      void'(q_lo.pop_front());
      void'(q_hi.pop_front());
    end
    zerr_m = acc && (i == 4'd0);
    if (acc)
      for (int b = 0; b < 4; b++)
        if (i[b]) begin
          q_lo.push_back(b);
          q_hi.push_front(b);
        end
  endtask

  initial begin
    //            chk rst iv  i      ordy ov olo ohi last irdy zerr
    tbl[0]  = '{0, 1, 0, 0,      0,   0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0,      0,   0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 1, 4'hB,   1,   0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 0,      1,   1, 0, 3, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0,      1,   1, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0,      1,   1, 3, 0, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 4'h6,   0,   0, 0, 0, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 0,      0,   1, 1, 2, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0,      0,   1, 1, 2, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 4'hF,   0,   1, 1, 2, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0,      1,   1, 1, 2, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0,      1,   1, 2, 1, 1, 1, 0};
    tbl[12] = '{1, 0, 1, 4'h1,   1,   0, 0, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 1, 4'h8,   1,   1, 0, 0, 1, 1, 0};
    tbl[14] = '{1, 0, 1, 4'h0,   1,   1, 3, 3, 1, 1, 0};
    tbl[15] = '{1, 0, 0, 0,      1,   0, 0, 0, 0, 1, 1};
    tbl[16] = '{1, 0, 1, 4'h0,   1,   0, 0, 0, 0, 1, 0};
    tbl[17] = '{1, 0, 0, 0,      1,   0, 0, 0, 0, 1, 1};
    tbl[18] = '{1, 0, 1, 4'hF,   1,   0, 0, 0, 0, 1, 0};
    tbl[19] = '{1, 0, 0, 0,      1,   1, 0, 3, 0, 0, 0};
    tbl[20] = '{1, 0, 0, 0,      1,   1, 1, 2, 0, 0, 0};
    tbl[21] = '{1, 1, 0, 0,      1,   1, 2, 1, 0, 0, 0};
    tbl[22] = '{1, 0, 1, 4'h4,   1,   0, 0, 0, 0, 1, 0};
    tbl[23] = '{1, 0, 0, 0,      1,   1, 2, 2, 1, 1, 0};
    tbl[24] = '{1, 0, 0, 0,      1,   0, 0, 0, 0, 1, 0};
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      rst = tbl[k].rst[0];
      in_valid = tbl[k].iv[0];
      i = 4'(tbl[k].i);
      out_ready = tbl[k].ordy[0];
      #1;
      if (tbl[k].chk != 0)
        check_all(tbl[k].ov, tbl[k].olo, tbl[k].ohi, tbl[k].last, tbl[k].irdy, tbl[k].zerr);
      @(posedge clk);
      model_step();
    end
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = (k < 2) || ($urandom_range(0, 149) == 0);
      in_valid = $urandom_range(0, 2) != 0;
      i = 4'($urandom_range(0, 15));
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (k >= 1) begin
        int n;
        n = q_lo.size();
        check_all(int'(n > 0), n > 0 ? q_lo[0] : 0, n > 0 ? q_hi[0] : 0, int'(n == 1),
                  int'(n == 0 || (out_ready && n == 1)), int'(zerr_m));
      end
      @(posedge clk);
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
